booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 129 ++++++++++++
 tb/tb_booth_mult_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one ARITH and one SHIFT cycle per operand bit.
// Optional cancel port enabled by defining BOOTH_ABORT_EN.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
`ifdef BOOTH_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ARITH, SHIFT, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             q_m1;
  logic [CW-1:0]    cnt;
  logic             abort_c;

  logic [AW-1:0]    acc_sh_c;
  logic [WIDTH-1:0] mplier_sh_c;

`ifdef BOOTH_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Arithmetic right shift of {acc, mplier, q_m1}; q_m1 picks up mplier[0].
  assign acc_sh_c    = {acc[AW-1], acc[AW-1:1]};
  assign mplier_sh_c = {acc[0], mplier[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {multiplicand[WIDTH-1], multiplicand};
            mplier   <= multiplier;
            acc      <= '0;
            q_m1     <= 1'b0;
            cnt      <= CW'(WIDTH);
            state    <= ARITH;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ARITH: begin
          if (abort_c) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            case ({mplier[0], q_m1})
              2'b01:   acc <= acc + mcand;
              2'b10:   acc <= acc - mcand;
              default: acc <= acc;
            endcase
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort_c) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            acc    <= acc_sh_c;
            mplier <= mplier_sh_c;
            q_m1   <= mplier[0];
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              product   <= {acc_sh_c[WIDTH-1:0], mplier_sh_c};
            end else begin
              state <= ARITH;
            end
          end
        end

        DONE: begin
          if (out_ready || abort_c) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=8); covers abort when BOOTH_ABORT_EN is defined.
module tb_booth_mult_seq;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mc;
  logic [W-1:0]   mq;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef BOOTH_ABORT_EN
  logic           abort;
`endif

  int             n_vec = 0;
  int             n_err = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_prod;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (mc),
    .multiplier   (mq),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
`ifdef BOOTH_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic signed [W-1:0] m, input logic signed [W-1:0] q);
    int p;
    p = int'(m) * int'(q);
    return (2*W)'(p);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int hold, input bit hammer);
    int lat;
    logic [2*W-1:0] e;
    check("accept_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    mc = m;
    mq = q;
    @(posedge clk);
    sb.push_back(model(m, q));
    @(negedge clk);
    in_valid = hammer;
    if (hammer) begin mc = W'($urandom); mq = W'($urandom); end
    check("busy", 64'(busy), 64'd1);
    lat = 0;
    while (lat < 4*W) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (hammer) begin mc = W'($urandom); mq = W'($urandom); end
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(2*W));
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check("product", 64'(product), 64'(e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_prod", 64'(product), 64'(e));
      check("hold_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_rdy", 64'(in_ready), 64'd1);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_retain", 64'(product), 64'(e));
    last_prod = e;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mc = '0; mq = '0;
    last_prod = '0;
`ifdef BOOTH_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_prod", 64'(product), 64'd0);
    rst_n = 1'b1;

    run_op(8'h03, 8'hFE, 0, 1'b0);
    check("m3_q-2", 64'(last_prod), 64'h0000_FFFA);
    run_op(8'h80, 8'h80, 0, 1'b0);
    check("min_min", 64'(last_prod), 64'h0000_4000);
    run_op(8'h7F, 8'h80, 1, 1'b0);
    check("max_min", 64'(last_prod), 64'h0000_C080);
    run_op(8'h00, 8'hFF, 0, 1'b0);
    check("zero", 64'(last_prod), 64'h0);
    run_op(8'hFB, 8'h07, 5, 1'b0);
    check("m-5_q7", 64'(last_prod), 64'h0000_FFDD);
    run_op(8'h11, 8'hE3, 0, 1'b1);

    // Reset in the middle of an operation.
    in_valid = 1'b1; mc = 8'h05; mq = 8'h09;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_prod", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h02, 8'h03, 0, 1'b0);
    check("after_rst", 64'(last_prod), 64'h6);

`ifdef BOOTH_ABORT_EN
    begin
      bit seen;
      int lat;
      in_valid = 1'b1; mc = 8'd10; mq = 8'd10;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      check("abort_rdy", 64'(in_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_prod", 64'(product), 64'(last_prod));
      seen = 1'b0;
      repeat (20) begin @(negedge clk); seen |= out_valid; end
      check("abort_no_valid", 64'(seen), 64'd0);

      // Abort in IDLE is ignored; the offered pair is still accepted.
      abort = 1'b1; in_valid = 1'b1; mc = 8'd4; mq = 8'd4;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      check("idle_abort_accept", 64'(busy), 64'd1);
      lat = 0;
      while (!out_valid && lat < 4*W) begin @(negedge clk); lat++; end
      check("abort_done_valid", 64'(out_valid), 64'd1);
      check("abort_done_prod", 64'(product), 64'h10);
      abort = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0; out_ready = 1'b0;
      check("abort_done_rdy", 64'(in_ready), 64'd1);
      check("abort_done_keep", 64'(product), 64'h10);
      run_op(8'd10, 8'd10, 0, 1'b0);
      check("after_abort", 64'(last_prod), 64'h64);
    end
`endif

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), $urandom_range(0, 2), 1'b0);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
